gray_addr_sched: RTL and testbench

Arbitrates between two requesters that each need a burst of sequential addresses from a shared address generator. The generator emits each address in both binary and Gray form, and Gray codes are formed as addr ^ (addr >> 1). The block sits in front of the team's Gray-coded address consumers, such as memory or pointer logic. It owns arbitration, burst sequencing and the valid/ready output handshake.

---
 rtl/gray_addr_sched.sv | 109 ++++++++++
 tb/tb_gray_addr_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_addr_sched.sv
// gray_addr_sched: round-robin arbiter for two burst requesters driving a shared
// address generator that emits binary and Gray addresses over a valid/ready handshake.
module gray_addr_sched #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] base0,
    input  logic [LEN_W-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] base1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] addr_bin,
    output logic [WIDTH-1:0] addr_gray,
    output logic             addr_vld,
    input  logic             addr_rdy,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, GRANT, BURST, DONE} state_t;

    state_t           state, state_nx;
    logic             sel, sel_nx, ptr, ptr_nx, win;
    logic [WIDTH-1:0] base_q, base_nx, bin_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic             gnt0_nx, gnt1_nx, done0_nx, done1_nx, vld_nx;

    // ptr names the requester favoured when both ask at once
    assign win  = (req0 && req1) ? ptr : req1;
    assign busy = state != IDLE;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        base_nx  = base_q;
        cnt_nx   = cnt;
        bin_nx   = addr_bin;
        vld_nx   = addr_vld;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        done0_nx = 1'b0;
        done1_nx = 1'b0;
        case (state)
            IDLE: if (req0 || req1) begin
                state_nx = GRANT;
                sel_nx   = win;
                base_nx  = win ? base1 : base0;
                cnt_nx   = win ? len1 : len0;
                gnt0_nx  = !win;
                gnt1_nx  = win;
            end
            GRANT: begin
                bin_nx   = base_q;
                vld_nx   = cnt != '0;
                state_nx = (cnt != '0) ? BURST : DONE;
            end
            BURST: if (addr_vld && addr_rdy) begin
                bin_nx = addr_bin + WIDTH'(1);
                cnt_nx = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    vld_nx   = 1'b0;
                    state_nx = DONE;
                end
            end
            default: begin
                done0_nx = !sel;
                done1_nx = sel;
                ptr_nx   = !sel;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            ptr       <= 1'b0;
            base_q    <= '0;
            cnt       <= '0;
            addr_bin  <= '0;
            addr_gray <= '0;
            addr_vld  <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            ptr       <= ptr_nx;
            base_q    <= base_nx;
            cnt       <= cnt_nx;
            addr_bin  <= bin_nx;
            addr_gray <= bin_nx ^ (bin_nx >> 1);
            addr_vld  <= vld_nx;
            gnt0      <= gnt0_nx;
            gnt1      <= gnt1_nx;
            done0     <= done0_nx;
            done1     <= done1_nx;
        end
    end
endmodule

// File: tb/tb_gray_addr_sched.sv
// tb_gray_addr_sched: directed tests against a burst-level scoreboard model
// of gray_addr_sched, plus literal expectations for each scenario.
module tb_gray_addr_sched;
    logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, addr_rdy = 1'b0;
    logic [7:0] base0 = '0, base1 = '0, len0 = '0, len1 = '0;
    logic       gnt0, gnt1, done0, done1, addr_vld, busy;
    logic [7:0] addr_bin, addr_gray;

    gray_addr_sched #(.WIDTH(8), .LEN_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req0(req0), .base0(base0), .len0(len0),
        .req1(req1), .base1(base1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .addr_bin(addr_bin), .addr_gray(addr_gray), .addr_vld(addr_vld),
        .addr_rdy(addr_rdy), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_fail = 0;
    int gnt_log[$], done_log[$];
    logic [7:0] beat_bin[$], beat_gray[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Burst-level model: phase 0 idle, 1 grant shown, 2 beats, 3 tail, 4 done shown
    int         phase = 0, m_left = 0;
    bit         fav = 1'b0, cur = 1'b0;
    logic [7:0] m_addr = '0;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            phase = 0;
            fav   = 1'b0;
        end else begin
            chk("gnt0", gnt0, phase == 1 && !cur);
            chk("gnt1", gnt1, phase == 1 && cur);
            chk("done0", done0, phase == 4 && !cur);
            chk("done1", done1, phase == 4 && cur);
            chk("addr_vld", addr_vld, phase == 2);
            chk("busy", busy, phase inside {1, 2, 3});
            if (phase == 2) begin
                chk("addr_bin", addr_bin, m_addr);
                chk("addr_gray", addr_gray, m_addr ^ (m_addr >> 1));
            end
            if (gnt0) gnt_log.push_back(0);
            if (gnt1) gnt_log.push_back(1);
            if (done0) done_log.push_back(0);
            if (done1) done_log.push_back(1);
            if (addr_vld && addr_rdy) begin
                beat_bin.push_back(addr_bin);
                beat_gray.push_back(addr_gray);
            end
            case (phase)
                1: phase = (m_left != 0) ? 2 : 3;
                2: if (addr_rdy) begin
                    m_addr++;
                    m_left--;
                    if (m_left == 0) phase = 3;
                end
                3: phase = 4;
                default: begin
                    if (phase == 4) fav = !cur;
                    phase = 0;
                    if (req0 || req1) begin
                        cur    = (req0 && req1) ? fav : req1;
                        m_addr = cur ? base1 : base0;
                        m_left = cur ? int'(len1) : int'(len0);
                        phase  = 1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_gnt(input int id);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge sys_clk);
            seen = (id == 0) ? gnt0 : gnt1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_gnt%0d: got timeout expected grant", id);
        end
    endtask

    task automatic wait_done(input int id);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge sys_clk);
            seen = (id == 0) ? done0 : done1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done%0d: got timeout expected done", id);
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        done_log.delete();
        beat_bin.delete();
        beat_gray.delete();
    endtask

    logic [7:0] t1_bin[4]  = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] t1_gray[4] = '{8'h18, 8'h19, 8'h1B, 8'h1A};
    logic [7:0] t2_bin[3]  = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] t2_gray[3] = '{8'h81, 8'h80, 8'h00};

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("reset busy", busy, 0);
        chk("reset addr_vld", addr_vld, 0);
        chk("reset gnt0", gnt0, 0);
        tick();
        sys_rst_n = 1'b1;
        tick();

        // single burst
        clear_logs();
        base0 = 8'h10; len0 = 8'd4; addr_rdy = 1'b1; req0 = 1'b1;
        wait_gnt(0);
        tick(); req0 = 1'b0;
        wait_done(0);
        tick();
        @(negedge sys_clk);
        chk("t1 busy after", busy, 0);
        chk("t1 beats", beat_bin.size(), 4);
        for (int i = 0; i < 4 && i < beat_bin.size(); i++) begin
            chk("t1 bin", beat_bin[i], t1_bin[i]);
            chk("t1 gray", beat_gray[i], t1_gray[i]);
        end

        // backpressure and wrap
        clear_logs();
        tick();
        addr_rdy = 1'b0; base1 = 8'hFE; len1 = 8'd3; req1 = 1'b1;
        wait_gnt(1);
        tick(); addr_rdy = 1'b1; req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            addr_rdy = ~addr_rdy;
        end
        wait_done(1);
        addr_rdy = 1'b1;
        tick();
        chk("t2 handshakes", beat_bin.size(), 3);
        for (int i = 0; i < 3 && i < beat_bin.size(); i++) begin
            chk("t2 bin", beat_bin[i], t2_bin[i]);
            chk("t2 gray", beat_gray[i], t2_gray[i]);
        end

        // simultaneous requests from reset
        sys_rst_n = 1'b0;
        tick();
        clear_logs();
        base0 = 8'h20; len0 = 8'd2; base1 = 8'h30; len1 = 8'd2;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 200 && gnt_log.size() < 4; i++) @(negedge sys_clk);
        tick(); req0 = 1'b0; req1 = 1'b0;
        wait_done(1);
        tick();
        chk("t3 grants", gnt_log.size(), 4);
        chk("t3 dones", done_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("t3 order", gnt_log[i], i % 2);

        // zero length
        clear_logs();
        base0 = 8'h55; len0 = 8'd0; req0 = 1'b1;
        wait_gnt(0);
        @(posedge sys_clk); #1 req0 = 1'b0;
        @(negedge sys_clk);
        chk("t4 done0 +1", done0, 0);
        chk("t4 vld +1", addr_vld, 0);
        @(negedge sys_clk);
        chk("t4 done0 +2", done0, 1);
        chk("t4 vld +2", addr_vld, 0);
        tick();
        chk("t4 beats", beat_bin.size(), 0);

        // reset during beat 2 of an 8-beat burst
        base0 = 8'h40; len0 = 8'd8; req0 = 1'b1;
        wait_gnt(0);
        @(posedge sys_clk); #1 req0 = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("t5 beat2 addr", addr_bin, 8'h41);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t5 rst vld", addr_vld, 0);
        chk("t5 rst bin", addr_bin, 0);
        chk("t5 rst gray", addr_gray, 0);
        chk("t5 rst busy", busy, 0);
        chk("t5 rst gnt", {gnt0, gnt1}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("t5 no done", {done0, done1}, 0);
        end
        clear_logs();
        base0 = 8'h70; len0 = 8'd1; base1 = 8'h71; len1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        sys_rst_n = 1'b1;
        wait_gnt(0);
        tick(); req0 = 1'b0;
        wait_gnt(1);
        tick(); req1 = 1'b0;
        wait_done(1);
        tick();
        chk("t5 grants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) chk("t5 first", gnt_log[0], 0);

        // request withdrawn mid-burst, short req0 pulse while busy
        clear_logs();
        base1 = 8'h80; len1 = 8'd5; req1 = 1'b1;
        wait_gnt(1);
        tick(); req1 = 1'b0;
        tick(); base0 = 8'h90; len0 = 8'd2; req0 = 1'b1;
        tick();
        tick(); req0 = 1'b0;
        wait_done(1);
        repeat (3) tick();
        chk("t6 beats", beat_bin.size(), 5);
        chk("t6 grants", gnt_log.size(), 1);
        chk("t6 dones", done_log.size(), 1);
        if (beat_bin.size() == 5) chk("t6 last", beat_bin[4], 8'h84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
